// File: rtl/alu_adder_unit.sv
// rtl/alu_adder_unit.sv - RV32I integer ALU with registered result and standalone PC adder

// Carry-propagate adder. It is kept independent of the ALU so it can be instantiated at any width.
module alu_adder_unit_cpa #(
   parameter int AW = 16
) (
   input  logic [AW-1:0] a_i,
   input  logic [AW-1:0] b_i,
   input  logic          cin_i,
   output logic [AW-1:0] sum_o,
   output logic          cout_o
);

   logic [AW:0] full_sum;

   always_comb begin
      full_sum = {1'b0, a_i} + {1'b0, b_i} + {{AW{1'b0}}, cin_i};
   end

   assign sum_o  = full_sum[AW-1:0];
   assign cout_o = full_sum[AW];

endmodule

// Combinational ALU core. fn is {funct7[5], funct3}, and unused codes return zero.
module alu_adder_unit_alu #(
   parameter int W = 32
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic [3:0]   fn_i,
   output logic [W-1:0] res_o,
   output logic         zero_o
);

   localparam int SW = $clog2(W);

   logic [SW-1:0] shamt;
   logic [W-1:0]  sum;
   logic [W-1:0]  diff;
   logic          lt_s;
   logic          lt_u;

   assign shamt = y_i[SW-1:0];
   assign sum   = x_i + y_i;
   assign diff  = x_i - y_i;
   assign lt_s  = $signed(x_i) < $signed(y_i);
   assign lt_u  = x_i < y_i;

   always_comb begin
      res_o = '0;
      unique case (fn_i)
         4'h0:    res_o = sum;
         4'h8:    res_o = diff;
         4'h1:    res_o = x_i << shamt;
         4'h2:    res_o = {{(W-1){1'b0}}, lt_s};
         4'h3:    res_o = {{(W-1){1'b0}}, lt_u};
         4'h4:    res_o = x_i ^ y_i;
         4'h5:    res_o = x_i >> shamt;
         4'hD:    res_o = $unsigned($signed(x_i) >>> shamt);
         4'h6:    res_o = x_i | y_i;
         4'h7:    res_o = x_i & y_i;
         default: res_o = '0;
      endcase
   end

   assign zero_o = (res_o == '0);

endmodule

module alu_adder_unit #(
   parameter int W  = 32,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  x,
   input  logic [W-1:0]  y,
   input  logic [3:0]    fn,
   output logic [W-1:0]  out,
   output logic          zero,
   input  logic          en,
   output logic [W-1:0]  out_q,
   output logic          zero_q,
   input  logic [AW-1:0] add_a,
   input  logic [AW-1:0] add_b,
   input  logic          add_cin,
   output logic [AW-1:0] add_sum,
   output logic          add_cout
);

   logic [W-1:0] res_d;
   logic [W-1:0] res_q;
   logic         zero_d;
   logic         zero_flag_q;

   alu_adder_unit_alu #(.W(W)) u_alu (
      .x_i    (x),
      .y_i    (y),
      .fn_i   (fn),
      .res_o  (out),
      .zero_o (zero)
   );

   alu_adder_unit_cpa #(.AW(AW)) u_cpa (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   always_comb begin
      res_d  = res_q;
      zero_d = zero_flag_q;
      if (en) begin
         res_d  = out;
         zero_d = zero;
      end
   end

   // The reset value keeps zero_q consistent with out_q == 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q       <= '0;
         zero_flag_q <= 1'b1;
      end else begin
         res_q       <= res_d;
         zero_flag_q <= zero_d;
      end
   end

   assign out_q  = res_q;
   assign zero_q = zero_flag_q;

endmodule

// File: tb/tb_alu_adder_unit.sv
// tb/tb_alu_adder_unit.sv - directed self-checking bench for alu_adder_unit

module tb_alu_adder_unit;

   logic        clk;
   logic        rst;
   logic [31:0] x;
   logic [31:0] y;
   logic [3:0]  fn;
   logic [31:0] out;
   logic        zero;
   logic        en;
   logic [31:0] out_q;
   logic        zero_q;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;

   int n_checks = 0;
   int n_errors = 0;

   alu_adder_unit #(.W(32), .AW(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .x        (x),
      .y        (y),
      .fn       (fn),
      .out      (out),
      .zero     (zero),
      .en       (en),
      .out_q    (out_q),
      .zero_q   (zero_q),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input string tag, input logic [31:0] exp_out, input logic exp_zero);
      fn = f;
      x  = a;
      y  = b;
      #1;
      check({tag, ".out"}, out, exp_out);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
   endtask

   task automatic adder(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input string tag, input logic [15:0] exp_sum, input logic exp_cout);
      add_a   = a;
      add_b   = b;
      add_cin = c;
      #1;
      check({tag, ".sum"}, {16'd0, add_sum}, {16'd0, exp_sum});
      check({tag, ".cout"}, {31'd0, add_cout}, {31'd0, exp_cout});
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; x = '0; y = '0; fn = 4'h0;
      add_a = '0; add_b = '0; add_cin = 1'b0;

      @(posedge clk); #1;
      check("rst.out_q", out_q, 32'h0);
      check("rst.zero_q", {31'd0, zero_q}, 32'h1);

      alu(4'h0, 32'hFFFF_FFFF, 32'h1, "add_wrap", 32'h0, 1'b1);
      alu(4'h8, 32'h5, 32'h7, "sub_neg", 32'hFFFF_FFFE, 1'b0);
      alu(4'h2, 32'hFFFF_FFFF, 32'h1, "slt", 32'h1, 1'b0);
      alu(4'h3, 32'hFFFF_FFFF, 32'h1, "sltu", 32'h0, 1'b1);
      alu(4'h8, 32'h3, 32'h3, "beq", 32'h0, 1'b1);
      alu(4'h1, 32'h8000_0010, 32'h4, "sll", 32'h0000_0100, 1'b0);
      alu(4'h5, 32'h8000_0010, 32'h4, "srl", 32'h0800_0001, 1'b0);
      alu(4'hD, 32'h8000_0010, 32'h4, "sra", 32'hF800_0001, 1'b0);
      alu(4'hD, 32'h8000_0010, 32'h24, "sra_hi", 32'hF800_0001, 1'b0);
      alu(4'h1, 32'h8000_0010, 32'h3F, "sll_31", 32'h0000_0000, 1'b1);
      alu(4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "xor", 32'hFF00_FF00, 1'b0);
      alu(4'h6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "or", 32'hFFF0_FFF0, 1'b0);
      alu(4'h7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "and", 32'h00F0_00F0, 1'b0);
      alu(4'hA, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "unused_a", 32'h0, 1'b1);
      alu(4'hF, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "unused_f", 32'h0, 1'b1);

      adder(16'h0100, 16'h0004, 1'b0, "pc4", 16'h0104, 1'b0);
      adder(16'hFFFC, 16'h0004, 1'b0, "wrap", 16'h0000, 1'b1);
      adder(16'h1234, 16'h0000, 1'b1, "cin", 16'h1235, 1'b0);
      adder(16'hFFFF, 16'hFFFF, 1'b1, "max", 16'hFFFF, 1'b1);

      @(negedge clk);
      rst = 1'b0; en = 1'b1; fn = 4'h0; x = 32'h2; y = 32'h3;
      @(posedge clk); #1;
      check("cap.out_q", out_q, 32'h5);
      check("cap.zero_q", {31'd0, zero_q}, 32'h0);

      @(negedge clk);
      en = 1'b0; x = 32'h7; y = 32'h7; fn = 4'h8;
      @(posedge clk); #1;
      check("hold.out_q", out_q, 32'h5);
      check("hold.zero_q", {31'd0, zero_q}, 32'h0);

      @(negedge clk);
      rst = 1'b1; en = 1'b1; x = 32'h9; y = 32'h1; fn = 4'h0;
      @(posedge clk); #1;
      check("rst_en.out_q", out_q, 32'h0);
      check("rst_en.zero_q", {31'd0, zero_q}, 32'h1);
      check("rst_comb.out", out, 32'hA);

      @(negedge clk);
      rst = 1'b0; en = 1'b1; x = 32'h4; y = 32'h4; fn = 4'h8;
      @(posedge clk); #1;
      check("cap_zero.out_q", out_q, 32'h0);
      check("cap_zero.zero_q", {31'd0, zero_q}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
